subleq_ctrl: RTL and testbench

SUBLEQ_CTRL -- requirements
Module: subleq_ctrl

---
 rtl/subleq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_subleq_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subleq_ctrl.sv
// subleq_ctrl: multi-cycle SUBLEQ sequencer driving an external PC register and a
// single-port memory. Define SUBLEQ_INSTR_COUNT_EN to add the instr_count output.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module subleq_ctrl #(
  parameter logic [`WORD_SIZE-1:0] HALT_ADDR = {`WORD_SIZE{1'b1}}
) (
  input  logic                  clk,
  input  logic                  areset_n,
  input  logic [`WORD_SIZE-1:0] pc,
  output logic                  pc_inc,
  output logic                  pc_branch,
  output logic [`WORD_SIZE-1:0] pc_addr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [`WORD_SIZE-1:0] mem_addr,
  output logic [`WORD_SIZE-1:0] mem_wdata,
  input  logic [`WORD_SIZE-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  halted
`ifdef SUBLEQ_INSTR_COUNT_EN
  ,
  output logic [31:0]           instr_count
`endif
);

  localparam int W = `WORD_SIZE;

  typedef enum logic [2:0] {
    FETCH_A = 3'd0,
    FETCH_B = 3'd1,
    FETCH_C = 3'd2,
    READ_A  = 3'd3,
    READ_B  = 3'd4,
    WRITE   = 3'd5,
    DECIDE  = 3'd6,
    HALT    = 3'd7
  } state_t;

  state_t       state_reg;
  state_t       state_next;
  logic         active_reg;
  logic [W-1:0] a_reg;
  logic [W-1:0] b_reg;
  logic [W-1:0] c_reg;
  logic [W-1:0] va_reg;
  logic [W-1:0] vb_reg;
  logic [W-1:0] result_reg;
  logic [W-1:0] diff;
  logic         xfer_done;
  logic         branch_taken;

  assign diff         = vb_reg - va_reg;
  assign branch_taken = result_reg[W-1] | (result_reg == '0);
  assign xfer_done    = mem_req & mem_ack;

  // active_reg holds every output quiet until the first edge after reset release
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_reg  <= FETCH_A;
      active_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      active_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH_A: if (xfer_done) state_next = FETCH_B;
      FETCH_B: if (xfer_done) state_next = FETCH_C;
      FETCH_C: if (xfer_done) state_next = READ_A;
      READ_A:  if (xfer_done) state_next = READ_B;
      READ_B:  if (xfer_done) state_next = WRITE;
      WRITE:   if (xfer_done) state_next = DECIDE;
      DECIDE:  state_next = (branch_taken && (c_reg == HALT_ADDR)) ? HALT : FETCH_A;
      HALT:    state_next = HALT;
      default: state_next = FETCH_A;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    pc_inc    = 1'b0;
    pc_branch = 1'b0;
    pc_addr   = '0;
    halted    = 1'b0;
    if (active_reg) begin
      case (state_reg)
        FETCH_A, FETCH_B, FETCH_C: begin
          mem_req  = 1'b1;
          mem_addr = pc;
          pc_inc   = mem_ack;
        end
        READ_A: begin
          mem_req  = 1'b1;
          mem_addr = a_reg;
        end
        READ_B: begin
          mem_req  = 1'b1;
          mem_addr = b_reg;
        end
        WRITE: begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = b_reg;
          mem_wdata = diff;
        end
        DECIDE: begin
          pc_branch = branch_taken;
          pc_addr   = branch_taken ? c_reg : '0;
        end
        HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      c_reg      <= '0;
      va_reg     <= '0;
      vb_reg     <= '0;
      result_reg <= '0;
    end else if (xfer_done) begin
      case (state_reg)
        FETCH_A: a_reg      <= mem_rdata;
        FETCH_B: b_reg      <= mem_rdata;
        FETCH_C: c_reg      <= mem_rdata;
        READ_A:  va_reg     <= mem_rdata;
        READ_B:  vb_reg     <= mem_rdata;
        WRITE:   result_reg <= diff;
        default: ;
      endcase
    end
  end

`ifdef SUBLEQ_INSTR_COUNT_EN
  logic [31:0] instr_count_reg;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      instr_count_reg <= '0;
    end else if (state_reg == DECIDE) begin
      instr_count_reg <= instr_count_reg + 32'd1;
    end
  end

  assign instr_count = instr_count_reg;
`endif

endmodule

// File: tb/tb_subleq_ctrl.sv
// tb_subleq_ctrl: table-driven SUBLEQ programs against a behavioural PC register and
// wait-state memory, with a write scoreboard and hand-written reset/halt/counter cases.
`timescale 1ns/1ps
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module tb_subleq_ctrl;

  localparam int W = `WORD_SIZE;

  logic         clk = 1'b0;
  logic         areset_n = 1'b0;
  logic [W-1:0] pc = '0;
  logic         pc_inc, pc_branch, mem_req, mem_we, mem_ack, halted;
  logic [W-1:0] pc_addr, mem_addr, mem_wdata, mem_rdata;
`ifdef SUBLEQ_INSTR_COUNT_EN
  logic [31:0]  instr_count;
`endif

  always #5 clk = ~clk;

  subleq_ctrl dut (
    .clk       (clk),
    .areset_n  (areset_n),
    .pc        (pc),
    .pc_inc    (pc_inc),
    .pc_branch (pc_branch),
    .pc_addr   (pc_addr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .halted    (halted)
`ifdef SUBLEQ_INSTR_COUNT_EN
    ,
    .instr_count (instr_count)
`endif
  );

  // behavioural memory: ack after ack_delay wait cycles, optional spurious/blocked acks
  logic [W-1:0] mem [0:255];
  int           ack_delay = 0;
  int           wait_cnt = 0;
  bit           block_write = 1'b0;
  bit           spurious_ack = 1'b0;

  always_comb begin
    mem_rdata = mem[mem_addr[7:0]];
    mem_ack   = spurious_ack |
                (mem_req && (wait_cnt >= ack_delay) && !(block_write && mem_we));
  end

  typedef struct {
    logic [W-1:0] a_addr;
    logic [W-1:0] b_addr;
    logic [W-1:0] c_val;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    int           delay;
    logic [W-1:0] res;
    logic         taken;
    logic         halt;
  } vec_t;

  typedef struct {
    logic [W-1:0] addr;
    logic [W-1:0] data;
  } wr_t;

  wr_t  sb_q[$];
  bit   sb_en = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  logic         s_req, s_we, s_ack, s_inc, s_br, s_halted;
  logic [W-1:0] s_addr, s_wdata, s_paddr;
  bit           prev_pending = 1'b0;
  logic         p_we;
  logic [W-1:0] p_addr, p_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // one clock: sample/check at negedge, then update memory and PC just after posedge
  task automatic clk_cycle();
    wr_t exp_wr;
    @(negedge clk);
    s_req = mem_req;  s_we = mem_we;  s_ack = mem_ack;  s_inc = pc_inc;
    s_br = pc_branch; s_halted = halted; s_addr = mem_addr; s_wdata = mem_wdata;
    s_paddr = pc_addr;
    if (prev_pending) begin
      check("hold_req", {31'd0, s_req}, 32'd1);
      check("hold_we", {31'd0, s_we}, {31'd0, p_we});
      check("hold_addr", {16'd0, s_addr}, {16'd0, p_addr});
      check("hold_wdata", {16'd0, s_wdata}, {16'd0, p_wdata});
    end
    prev_pending = s_req && !s_ack;
    p_we = s_we; p_addr = s_addr; p_wdata = s_wdata;
    if (s_inc || s_br) check("inc_branch_excl", {31'd0, s_inc & s_br}, 32'd0);
    if (s_req && s_we && s_ack && sb_en) begin
      if (sb_q.size() == 0) begin
        check("unexpected_write", {16'd0, s_addr}, 32'hFFFF_FFFF);
      end else begin
        exp_wr = sb_q.pop_front();
        check("write_addr", {16'd0, s_addr}, {16'd0, exp_wr.addr});
        check("write_data", {16'd0, s_wdata}, {16'd0, exp_wr.data});
      end
    end
    @(posedge clk);
    #1;
    if (s_req && s_we && s_ack) mem[s_addr[7:0]] = s_wdata;
    if (s_inc) pc = pc + 1'b1;
    else if (s_br) pc = s_paddr;
    if (s_req && !s_ack) wait_cnt++;
    else wait_cnt = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_pc_inc", {31'd0, pc_inc}, 32'd0);
    check("rst_pc_branch", {31'd0, pc_branch}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_pc_addr", {16'd0, pc_addr}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    areset_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    areset_n = 1'b1;
    wait_cnt = 0;
    prev_pending = 1'b0;
    #1;
    check("req_before_first_edge", {31'd0, mem_req}, 32'd0);
  endtask

  task automatic load_program(input vec_t v);
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0] = v.a_addr;
    mem[1] = v.b_addr;
    mem[2] = v.c_val;
    mem[v.a_addr[7:0]] = v.va;
    mem[v.b_addr[7:0]] = v.vb;
    pc = '0;
    ack_delay = v.delay;
  endtask

  task automatic run_vector(input vec_t v, input int idx);
    wr_t     w;
    bit      got_write;
    bit      done;
    int      n_inc;
    int      n_br;
    int      bad;
    logic [W-1:0] next_pc;
    load_program(v);
    w.addr = v.b_addr;
    w.data = v.res;
    sb_q.push_back(w);
    do_reset();
    got_write = 1'b0; done = 1'b0; n_inc = 0; n_br = 0;
    next_pc = v.taken ? v.c_val : 16'd3;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      clk_cycle();
      if (s_inc) n_inc++;
      if (s_br) n_br++;
      if (got_write) begin
        check("decide_cycle", cyc, 6 * (v.delay + 1));
        check("pc_branch", {31'd0, s_br}, {31'd0, v.taken});
        if (v.taken) check("pc_addr", {16'd0, s_paddr}, {16'd0, v.c_val});
        clk_cycle();
        if (v.halt) begin
          check("halted", {31'd0, s_halted}, 32'd1);
          spurious_ack = 1'b1;
          bad = 0;
          for (int k = 0; k < 22; k++) begin
            clk_cycle();
            if (s_req || s_inc || s_br || !s_halted) bad++;
          end
          spurious_ack = 1'b0;
          check("halt_quiet_cycles", bad, 0);
        end else begin
          check("next_fetch_req", {31'd0, s_req}, 32'd1);
          check("next_fetch_we", {31'd0, s_we}, 32'd0);
          check("next_fetch_addr", {16'd0, s_addr}, {16'd0, next_pc});
        end
        done = 1'b1;
      end else if (s_req && s_we && s_ack) begin
        got_write = 1'b1;
      end
    end
    if (!done) check("instr_timeout", 32'd0, 32'd1);
    check("pc_inc_pulses", n_inc, 3);
    check("pc_branch_pulses", n_br, {31'd0, v.taken});
    check("scoreboard_drained", sb_q.size(), 0);
    check("mem_result", {16'd0, mem[v.b_addr[7:0]]}, {16'd0, v.res});
    $display("vec %0d: A=%0d B=%0d C=0x%0h va=0x%0h vb=0x%0h wait=%0d -> mem[B]=0x%0h branch=%0d halt=%0d",
             idx, v.a_addr, v.b_addr, v.c_val, v.va, v.vb, v.delay, mem[v.b_addr[7:0]], n_br, v.halt);
    sb_q.delete();
  endtask

  vec_t vecs[9];

  initial begin
    bit found;
    //            A      B      C        va       vb       wait res      tk    halt
    vecs[0] = '{16'd3, 16'd4, 16'd6,   16'd5,   16'd2,    0, 16'hFFFD, 1'b1, 1'b0};
    vecs[1] = '{16'd3, 16'd4, 16'd6,   16'd1,   16'd5,    0, 16'h0004, 1'b0, 1'b0};
    vecs[2] = '{16'd3, 16'd4, 16'd6,   16'd5,   16'd2,    3, 16'hFFFD, 1'b1, 1'b0};
    vecs[3] = '{16'd3, 16'd3, 16'd9,   16'd7,   16'd7,    0, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{16'd5, 16'd6, 16'd8,   16'd1,   16'h8001, 1, 16'h8000, 1'b1, 1'b0};
    vecs[5] = '{16'd5, 16'd6, 16'd8,   16'hFFFF, 16'h7FFE, 0, 16'h7FFF, 1'b0, 1'b0};
    vecs[6] = '{16'd7, 16'd8, 16'd20,  16'h8000, 16'd0,   2, 16'h8000, 1'b1, 1'b0};
    vecs[7] = '{16'd5, 16'd6, 16'd8,   16'd0,   16'd1,    0, 16'h0001, 1'b0, 1'b0};
    vecs[8] = '{16'd3, 16'd4, 16'hFFFF, 16'd1,  16'd1,    0, 16'h0000, 1'b1, 1'b1};

    for (int i = 0; i < 9; i++) run_vector(vecs[i], i);

    // reset asserted in WRITE while the ack is withheld
    load_program(vecs[0]);
    sb_en = 1'b0;
    block_write = 1'b1;
    do_reset();
    found = 1'b0;
    for (int cyc = 0; cyc < 50 && !found; cyc++) begin
      clk_cycle();
      if (s_req && s_we) found = 1'b1;
    end
    check("reached_write", {31'd0, found}, 32'd1);
    #2;
    areset_n = 1'b0;
    #1;
    check("midwrite_req_drop", {31'd0, mem_req}, 32'd0);
    check("midwrite_we_drop", {31'd0, mem_we}, 32'd0);
    check("midwrite_addr_zero", {16'd0, mem_addr}, 32'd0);
    block_write = 1'b0;
    @(negedge clk);
    areset_n = 1'b1;
    wait_cnt = 0;
    prev_pending = 1'b0;
    #1;
    check("rerun_req_before_edge", {31'd0, mem_req}, 32'd0);
    clk_cycle();
    check("rerun_fetch_req", {31'd0, s_req}, 32'd1);
    check("rerun_fetch_we", {31'd0, s_we}, 32'd0);
    check("rerun_fetch_addr", {16'd0, s_addr}, 32'd3);
    check("abandoned_write", {16'd0, mem[4]}, 32'd2);
    $display("reset-in-WRITE: refetch at 0x%0h, mem[4]=0x%0h", s_addr, mem[4]);
    sb_en = 1'b1;

`ifdef SUBLEQ_INSTR_COUNT_EN
    begin
      vec_t lp;
      int   n_br;
      lp = '{16'd10, 16'd11, 16'd0, 16'd0, 16'd0, 0, 16'd0, 1'b1, 1'b0};
      load_program(lp);
      sb_en = 1'b0;
      do_reset();
      check("count_reset", instr_count, 32'd0);
      n_br = 0;
      for (int cyc = 0; cyc < 100 && n_br < 3; cyc++) begin
        clk_cycle();
        if (s_br) n_br++;
      end
      check("count_three", instr_count, 32'd3);
      force dut.instr_count_reg = 32'hFFFF_FFFF;
      #1;
      release dut.instr_count_reg;
      n_br = 0;
      for (int cyc = 0; cyc < 50 && n_br < 1; cyc++) begin
        clk_cycle();
        if (s_br) n_br++;
      end
      check("count_wrap", instr_count, 32'd0);
      $display("instr_count: wrapped to 0x%0h", instr_count);
      sb_en = 1'b1;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
